// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   dmem_arb_state_t : sequencer states (IDLE, ISSUE, WAIT, RESP)
//   PORT_CORE/PORT_DBG : requester port indices
//   MEM_AW_DEFAULT   : byte-address bits backed by data_mem (1 KiB)
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dmem_arb_state_t;

  localparam int unsigned PORT_CORE      = 0;
  localparam int unsigned PORT_DBG       = 1;
  localparam int unsigned MEM_AW_DEFAULT = 10;

endpackage

// File: rtl/dmem_arb_grant.sv
// dmem_arb_grant: winner select between the two request ports.
//   clk_i, rst_ni : clock, asynchronous active-low reset (RR pointer only)
//   req_i[1:0]    : request valids, bit N = port N
//   accept_i      : a request is accepted this cycle (pointer update strobe)
//   gnt_o         : winning port index (meaningful only when req_i != 0)
// Build option: DMEM_ARB_RR_EN selects round-robin on simultaneous requests;
// without it port 0 always has priority and no pointer flop exists.
module dmem_arb_grant (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_o
);

`ifdef DMEM_ARB_RR_EN
  // ptr_q holds the port granted last; reset to 1 so port 0 wins first.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_o = ~ptr_q;
    end else begin
      gnt_o = ~req_i[0];
    end
    ptr_d = accept_i ? gnt_o : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk_i, rst_ni, accept_i, req_i[1]};

  always_comb begin
    gnt_o = ~req_i[0];
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of single-ported data_mem.
//   Port 0 (core LSU) and port 1 (debug/loader): valid/ready request channel
//   (we, addr, wdata) and valid/ready response channel (rdata, err).
//   mem_read/mem_write/mem_addr/mem_wdata : registered drive to data_mem
//   mem_rdata : data_mem registered read data (1-cycle latency)
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, or
// IDLE -> RESP directly for out-of-range addresses (no memory strobe).
// req_ready is the only combinational output.
// Build option: DMEM_ARB_RR_EN (round-robin arbitration, see dmem_arb_grant).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = MEM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  dmem_arb_state_t state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]        req_v;
  logic              win;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              range_err;
  logic              rsp_fire;

  assign req_v  = {p1_req_valid, p0_req_valid};
  assign accept = (state_q == IDLE) && (req_v != 2'b00);

  dmem_arb_grant u_grant (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req_v),
    .accept_i (accept),
    .gnt_o    (win)
  );

  assign p0_req_ready = accept && (win == 1'(PORT_CORE));
  assign p1_req_ready = accept && (win == 1'(PORT_DBG));

  assign sel_we    = win ? p1_req_we    : p0_req_we;
  assign sel_addr  = win ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = win ? p1_req_wdata : p0_req_wdata;
  assign range_err = |sel_addr[ADDR_W-1:MEM_AW];

  assign rsp_fire = (state_q == RESP) && (gnt_q ? p1_rsp_ready : p0_rsp_ready);

  // Strobes are computed one state early so the memory drive is a plain flop
  // output that is high exactly during ISSUE.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_d   = win;
          we_d    = sel_we;
          err_d   = range_err;
          rdata_d = '0;
          if (range_err) begin
            state_d = RESP;
          end else begin
            state_d     = ISSUE;
            mem_read_d  = ~sel_we;
            mem_write_d = sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        rdata_d = we_q ? '0 : mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign p0_rsp_valid = (state_q == RESP) && (gnt_q == 1'(PORT_CORE));
  assign p1_rsp_valid = (state_q == RESP) && (gnt_q == 1'(PORT_DBG));
  assign p0_rsp_rdata = p0_rsp_valid ? rdata_q : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? rdata_q : '0;
  assign p0_rsp_err   = p0_rsp_valid && err_q;
  assign p1_rsp_err   = p1_rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by randomized traffic, checked
// cycle by cycle against a transaction-level reference model of the arbiter
// and a behavioural data_mem (word-indexed, registered read, word i = i).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       v, we, rr;
  logic [1:0][31:0] a, wd;
  logic [1:0]       rdy, rv, er;
  logic [1:0][31:0] rd;
  logic             mem_read, mem_write;
  logic [31:0]      mem_addr, mem_wdata;
  logic [31:0]      mem_rdata = '0;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_AW(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_req_valid (v[0]),
    .p0_req_ready (rdy[0]),
    .p0_req_we    (we[0]),
    .p0_req_addr  (a[0]),
    .p0_req_wdata (wd[0]),
    .p0_rsp_valid (rv[0]),
    .p0_rsp_ready (rr[0]),
    .p0_rsp_rdata (rd[0]),
    .p0_rsp_err   (er[0]),
    .p1_req_valid (v[1]),
    .p1_req_ready (rdy[1]),
    .p1_req_we    (we[1]),
    .p1_req_addr  (a[1]),
    .p1_req_wdata (wd[1]),
    .p1_rsp_valid (rv[1]),
    .p1_rsp_ready (rr[1]),
    .p1_rsp_rdata (rd[1]),
    .p1_rsp_err   (er[1]),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // data_mem stand-in: unwritten words read back their own word index.
  logic [31:0]  mem [256];
  logic [255:0] mem_wr = '0;
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[9:2]]    <= mem_wdata;
      mem_wr[mem_addr[9:2]] <= 1'b1;
    end
    if (mem_read) begin
      mem_rdata <= mem_wr[mem_addr[9:2]] ? mem[mem_addr[9:2]] : 32'(mem_addr[9:2]);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model state (transaction level).
  logic [31:0] ref_mem [int];
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          busy = 1'b0;
  logic        gnt_m = 1'b0, we_m = 1'b0, err_m = 1'b0, last_m = 1'b1;
  logic [31:0] addr_m = '0, wd_m = '0, rdat_m = '0;
  logic [1:0]  acc = '0;
  logic [1:0][31:0] last_rsp = '0;

  function automatic logic [31:0] ref_rd(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : 32'(i);
  endfunction

  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    logic       w;
    logic       exp_rv;
    logic       issue;
    if (!rst_n) begin
      busy   = 1'b0;
      last_m = 1'b1;
      acc    = '0;
      chk("rst_req_ready", 32'(rdy), 0);
      chk("rst_rsp_valid", 32'(rv), 0);
      chk("rst_rsp_err", 32'(er), 0);
      chk("rst_strobes", 32'({mem_read, mem_write}), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rdata0", rd[0], 0);
      chk("rst_rdata1", rd[1], 0);
    end else begin
      exp_rv = busy && (cyc >= acc_cyc + (err_m ? 1 : 3));
      chk("rsp_valid", 32'(rv), exp_rv ? (gnt_m ? 32'd2 : 32'd1) : 32'd0);
      if (exp_rv) begin
        chk("rsp_rdata", rd[gnt_m], rdat_m);
        chk("rsp_err", 32'(er[gnt_m]), 32'(err_m));
      end
      issue = busy && !err_m && (cyc == acc_cyc + 1);
      chk("mem_strobes", 32'({mem_read, mem_write}), issue ? 32'({~we_m, we_m}) : 32'd0);
      if (issue) begin
        chk("mem_addr", mem_addr, addr_m);
        if (we_m) chk("mem_wdata", mem_wdata, wd_m);
      end
      exp_rdy = 2'b00;
      w       = 1'b0;
      if (!busy && v != 2'b00) begin
        if (v == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
          w = ~last_m;
`else
          w = 1'b0;
`endif
        end else begin
          w = (v == 2'b10);
        end
        exp_rdy[w] = 1'b1;
      end
      chk("req_ready", 32'(rdy), 32'(exp_rdy));
      acc = exp_rdy;
      if (exp_rdy != 2'b00) begin
        busy    = 1'b1;
        gnt_m   = w;
        last_m  = w;
        we_m    = we[w];
        addr_m  = a[w];
        wd_m    = wd[w];
        err_m   = (addr_m >= 32'd1024);
        acc_cyc = cyc;
        rdat_m  = (err_m || we_m) ? 32'd0 : ref_rd(int'(addr_m[9:2]));
        if (!err_m && we_m) ref_mem[int'(addr_m[9:2])] = wd_m;
      end else if (exp_rv && rr[gnt_m]) begin
        busy = 1'b0;
        last_rsp[gnt_m] = rd[gnt_m];
      end
    end
    cyc++;
  end

  task automatic new_req(input int p);
    we[p] = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) a[p] = $urandom | 32'h400;
    else                           a[p] = 32'($urandom_range(0, 255));
    wd[p] = $urandom;
  endtask

  task automatic do_req(input int p, input logic w, input logic [31:0] ad, input logic [31:0] d);
    @(posedge clk); #1;
    v[p] = 1'b1; we[p] = w; a[p] = ad; wd[p] = d;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc[p]) begin
        v[p] = 1'b0;
        return;
      end
    end
    v[p] = 1'b0;
    chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!busy) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    v = '0; we = '0; a = '0; wd = '0; rr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rr = 2'b11;

    // Port 0 load of initialised word 5.
    do_req(0, 1'b0, 32'h14, 32'h0);
    wait_idle();
    chk("p0_load_0x14", last_rsp[0], 32'h5);

    // Port 1 store then load back.
    do_req(1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    wait_idle();
    chk("p1_store_rdata", last_rsp[1], 32'h0);
    do_req(1, 1'b0, 32'h40, 32'h0);
    wait_idle();
    chk("p1_load_0x40", last_rsp[1], 32'hDEAD_BEEF);

    // Out-of-range load: error response, no strobes.
    do_req(0, 1'b0, 32'h400, 32'h0);
    wait_idle();

    // Response back-pressure on port 1 with port 0 waiting.
    rr[1] = 1'b0;
    do_req(1, 1'b0, 32'h20, 32'h0);
    v[0] = 1'b1; we[0] = 1'b0; a[0] = 32'h24; wd[0] = '0;
    repeat (8) @(posedge clk);
    #1 rr[1] = 1'b1;
    for (int i = 0; i < 20 && !acc[0]; i++) begin
      @(posedge clk); #1;
    end
    if (!acc[0]) chk("hold_accept_timeout", 0, 1);
    v[0] = 1'b0;
    wait_idle();

    // Both ports requesting continuously.
    new_req(0); new_req(1);
    v = 2'b11;
    repeat (40) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (acc[p]) new_req(p);
    end
    v = 2'b00;
    wait_idle();

    // Reset during WAIT, then a fresh load.
    do_req(0, 1'b0, 32'h18, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_strobes", 32'({mem_read, mem_write}), 0);
    chk("async_rst_mem_addr", mem_addr, 0);
    chk("async_rst_rsp_valid", 32'(rv), 0);
    chk("async_rst_req_ready", 32'(rdy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_req(0, 1'b0, 32'h18, 32'h0);
    wait_idle();
    chk("post_rst_load_0x18", last_rsp[0], 32'h6);

    // Randomized traffic; a pending request is held until accepted.
    repeat (600) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!v[p] || acc[p]) begin
          if ($urandom_range(0, 2) != 0) begin
            v[p] = 1'b1;
            new_req(p);
          end else begin
            v[p] = 1'b0;
          end
        end
      end
      rr[0] = ($urandom_range(0, 3) != 0);
      rr[1] = ($urandom_range(0, 3) != 0);
    end
    v  = 2'b00;
    rr = 2'b11;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
